router_fsm_ctrl: RTL and testbench
==================================

Name: router_fsm_ctrl

Overview:
- Moore state machine that sequences the 1x3 router's input datapath.
- Decodes the header address and waits for the target FIFO to drain.
- Drives the header/payload/parity load strobes into the router register block and handles FIFO-full back-pressure.
- Sits between the input port and the register/synchronizer blocks; its state strobes are the sole control for header hold, data load, full-state capture and parity check.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs. Only 3 is supported; the address field is 2 bits.
- ADDR_W, 2, width of the header address field datain[ADDR_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- packet_valid  in  1  high while the source drives header/payload; falls on the parity byte.
- datain  in  2  header address bits (low bits of the input byte). Address 3 is invalid.
- fifo_full  in  1  full flag of the currently selected FIFO (muxed externally).
- fifo_empty  in  3  per-port FIFO empty flags, bit n = FIFO n.
- soft_reset  in  3  per-port soft reset pulses (read-timeout), bit n = FIFO n.
- parity_done  in  1  from the register block: parity byte captured.
- low_packet_valid  in  1  from the register block: packet_valid fell while a load was pending.
- detect_add  out  1  high in DECODE_ADDRESS.
- lfd_state  out  1  high in LOAD_FIRST_DATA.
- ld_state  out  1  high in LOAD_DATA.
- laf_state  out  1  high in LOAD_AFTER_FULL.
- full_state  out  1  high in FIFO_FULL_STATE.
- write_enb_reg  out  1  FIFO write enable: high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR.
- busy  out  1  source stall: high in every state except DECODE_ADDRESS and LOAD_DATA.
- dest_port  out  2  latched destination address, valid from LOAD_FIRST_DATA/WAIT_TILL_EMPTY onward.

Behaviour:
- Single clock; reset asynchronous active-low. All other state updates on the rising clk edge.
- Reset state: DECODE_ADDRESS, dest_port=0. Reset outputs: detect_add=1, busy=0, all other outputs 0.
- All outputs are Moore (decoded from the state register only); no output depends combinationally on inputs.
- dest_port captures datain when in DECODE_ADDRESS && packet_valid && datain!=3. It holds otherwise.
- States and transitions (priority order within a state):
  - DECODE_ADDRESS:
    - packet_valid && datain<3 && fifo_empty[datain] -> LOAD_FIRST_DATA.
    - packet_valid && datain<3 && !fifo_empty[datain] -> WAIT_TILL_EMPTY.
    - datain==3, or !packet_valid -> stay. The invalid-address packet is dropped; no strobes issued.
  - WAIT_TILL_EMPTY: fifo_empty[dest_port] -> LOAD_FIRST_DATA, else stay.
  - LOAD_FIRST_DATA: unconditionally -> LOAD_DATA (1 cycle; header written).
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - else !packet_valid -> LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_packet_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY: unconditionally -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Soft reset: soft_reset[dest_port] high in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next cycle.
  - Highest priority over all transitions above.
  - Soft reset of a non-selected port is ignored.
- Minimum packet latency: header accepted at cycle 0 in DECODE, then LFD at cycle 1, LD at cycle 2.
  - Minimum header-to-DECODE for a 1-payload packet: 5 cycles (DECODE, LFD, LD, LP, CPE).
- State encoding: binary 3-bit. Unused encodings recover to DECODE_ADDRESS.

Decomposition:
- Shared package router_pkg holds:
  - state enumeration router_state_t (8 states);
  - ADDR_W and NUM_PORTS;
  - constant ADDR_INVALID = 2'd3.
- No sub-module; the block is a single next-state/output process pair plus the dest_port latch.

Test Plan:
- Reset then packet_valid=1, datain=2'b01, fifo_empty=3'b111 -> detect_add=1 at cycle 0; lfd_state=1 at cycle 1; ld_state=1 and write_enb_reg=1 at cycle 2; dest_port=1.
- fifo_empty=3'b110, header addr 0 -> WAIT_TILL_EMPTY with busy=1. Set fifo_empty[0]=1 after 4 cycles -> lfd_state next cycle.
- In LOAD_DATA assert fifo_full for 3 cycles -> full_state=1 and busy=1 for 3 cycles, then laf_state=1 for 1 cycle with low_packet_valid=0, then ld_state=1.
- Drop packet_valid in LOAD_DATA -> LOAD_PARITY (write_enb_reg=1), then rst_int_reg=1 for exactly 1 cycle, then detect_add=1.
- Header datain=2'b11 with packet_valid=1 for 5 cycles -> detect_add stays 1, no lfd/ld strobes, dest_port unchanged.
- Soft reset tests:
  - In WAIT_TILL_EMPTY for port 2, pulse soft_reset=3'b100 -> DECODE_ADDRESS next cycle.
  - Pulse soft_reset=3'b001 instead -> state unchanged.
- Async reset: drop resetn mid-LOAD_DATA -> detect_add=1 and ld_state=0 immediately, without a clock edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input controller.
// Holds the FSM state enumeration and the strobe decode used by the controller.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_state_t;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic write_enb_reg;
    logic rst_int_reg;
    logic busy;
  } router_strobes_t;

  localparam router_strobes_t STROBES_RESET = '{
    detect_add: 1'b1, lfd_state: 1'b0, ld_state: 1'b0, laf_state: 1'b0,
    full_state: 1'b0, write_enb_reg: 1'b0, rst_int_reg: 1'b0, busy: 1'b0
  };

  // Per-port flag select; address 3 has no FIFO and always reads as 0.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0] vec,
                                    input logic [ADDR_W-1:0]    addr);
    case (addr)
      2'd0:    port_bit = vec[0];
      2'd1:    port_bit = vec[1];
      2'd2:    port_bit = vec[2];
      default: port_bit = 1'b0;
    endcase
  endfunction

  function automatic router_strobes_t decode_strobes(input router_state_t s);
    router_strobes_t o;
    o = '0;
    case (s)
      DECODE_ADDRESS: begin
        o.detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        o.lfd_state = 1'b1;
        o.busy      = 1'b1;
      end
      LOAD_DATA: begin
        o.ld_state      = 1'b1;
        o.write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        o.full_state = 1'b1;
        o.busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        o.laf_state     = 1'b1;
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      LOAD_PARITY: begin
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        o.rst_int_reg = 1'b1;
        o.busy        = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        o.busy = 1'b1;
      end
      default: begin
        o = STROBES_RESET;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/router_fsm_ctrl_if.sv
// Control bundle between the router input port, register block and FSM.
// The slave modport is the controller; the master modport is its environment.
interface router_fsm_ctrl_if;
  import router_pkg::*;

  logic                  packet_valid;
  logic [ADDR_W-1:0]     datain;
  logic                  fifo_full;
  logic [NUM_PORTS-1:0]  fifo_empty;
  logic [NUM_PORTS-1:0]  soft_reset;
  logic                  parity_done;
  logic                  low_packet_valid;

  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  write_enb_reg;
  logic                  rst_int_reg;
  logic                  busy;
  logic [ADDR_W-1:0]     dest_port;

  modport master (
    output packet_valid, datain, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy, dest_port
  );

  modport slave (
    input  packet_valid, datain, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy, dest_port
  );

endinterface

// File: rtl/router_fsm_ctrl.sv
// Moore controller sequencing header decode, payload/parity loads and
// FIFO-full back-pressure for the 1x3 router input datapath.
module router_fsm_ctrl
  import router_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  router_fsm_ctrl_if.slave   bus
);

  router_state_t     state_q;
  router_state_t     state_d;
  logic [ADDR_W-1:0] dest_port_q;
  logic [ADDR_W-1:0] dest_port_d;
  router_strobes_t   strobes_q;
  logic              hdr_ok_s;
  logic              sel_srst_s;

  assign hdr_ok_s   = bus.packet_valid && (bus.datain != ADDR_INVALID);
  assign sel_srst_s = port_bit(bus.soft_reset, dest_port_q);

  // Next-state selection; a soft reset on the selected port overrides everything.
  always_comb begin
    state_d = state_q;
    if (sel_srst_s && (state_q != DECODE_ADDRESS)) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (hdr_ok_s && port_bit(bus.fifo_empty, bus.datain)) begin
            state_d = LOAD_FIRST_DATA;
          end else if (hdr_ok_s) begin
            state_d = WAIT_TILL_EMPTY;
          end else begin
            state_d = DECODE_ADDRESS;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (port_bit(bus.fifo_empty, dest_port_q)) begin
            state_d = LOAD_FIRST_DATA;
          end else begin
            state_d = WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: begin
          state_d = LOAD_DATA;
        end
        LOAD_DATA: begin
          if (bus.fifo_full) begin
            state_d = FIFO_FULL_STATE;
          end else if (!bus.packet_valid) begin
            state_d = LOAD_PARITY;
          end else begin
            state_d = LOAD_DATA;
          end
        end
        FIFO_FULL_STATE: begin
          if (!bus.fifo_full) begin
            state_d = LOAD_AFTER_FULL;
          end else begin
            state_d = FIFO_FULL_STATE;
          end
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done) begin
            state_d = DECODE_ADDRESS;
          end else if (bus.low_packet_valid) begin
            state_d = LOAD_PARITY;
          end else begin
            state_d = LOAD_DATA;
          end
        end
        LOAD_PARITY: begin
          state_d = CHECK_PARITY_ERROR;
        end
        CHECK_PARITY_ERROR: begin
          if (bus.fifo_full) begin
            state_d = FIFO_FULL_STATE;
          end else begin
            state_d = DECODE_ADDRESS;
          end
        end
        default: begin
          state_d = DECODE_ADDRESS;
        end
      endcase
    end
  end

  // Destination latch: only a valid header seen in DECODE_ADDRESS updates it.
  always_comb begin
    if ((state_q == DECODE_ADDRESS) && hdr_ok_s) begin
      dest_port_d = bus.datain;
    end else begin
      dest_port_d = dest_port_q;
    end
  end

  // Strobes are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= DECODE_ADDRESS;
      dest_port_q <= 2'd0;
      strobes_q   <= STROBES_RESET;
    end else begin
      state_q     <= state_d;
      dest_port_q <= dest_port_d;
      strobes_q   <= decode_strobes(state_d);
    end
  end

  assign bus.detect_add    = strobes_q.detect_add;
  assign bus.lfd_state     = strobes_q.lfd_state;
  assign bus.ld_state      = strobes_q.ld_state;
  assign bus.laf_state     = strobes_q.laf_state;
  assign bus.full_state    = strobes_q.full_state;
  assign bus.write_enb_reg = strobes_q.write_enb_reg;
  assign bus.rst_int_reg   = strobes_q.rst_int_reg;
  assign bus.busy          = strobes_q.busy;
  assign bus.dest_port     = dest_port_q;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Scoreboard bench for router_fsm_ctrl: a behavioural model predicts the
// outputs after every clock edge and a monitor compares them to the DUT.
module tb_router_fsm_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  router_fsm_ctrl_if bus();

  router_fsm_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model phases, named after the packet life cycle rather than any encoding.
  localparam int P_IDLE = 0, P_WAIT = 1, P_HDR = 2, P_PAY = 3,
                 P_FULL = 4, P_AFTER = 5, P_PAR = 6, P_CHK = 7;
  int          m_phase;
  logic [1:0]  m_dest;
  logic [9:0]  exp_q[$];

  // {detect_add,lfd,ld,laf,full,wen,rst_int,busy,dest_port}
  function automatic logic [9:0] expect_of(int ph, logic [1:0] d);
    logic [7:0] s;
    case (ph)
      P_IDLE:  s = 8'b1000_0000;
      P_WAIT:  s = 8'b0000_0001;
      P_HDR:   s = 8'b0100_0001;
      P_PAY:   s = 8'b0010_0100;
      P_FULL:  s = 8'b0000_1001;
      P_AFTER: s = 8'b0001_0101;
      P_PAR:   s = 8'b0000_0101;
      default: s = 8'b0000_0011;
    endcase
    return {s, d};
  endfunction

  function automatic void check(string name, logic [9:0] act, logic [9:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, req, $time);
  endfunction

  // Advance the model by one edge using the inputs currently on the bus.
  task automatic model_step();
    int nxt;
    logic [1:0] a;
    a = bus.datain;
    nxt = m_phase;
    if (m_phase != P_IDLE && m_dest != 2'd3 && bus.soft_reset[m_dest]) nxt = P_IDLE;
    else case (m_phase)
      P_IDLE:  if (bus.packet_valid && a != 2'd3) begin
                 nxt = bus.fifo_empty[a] ? P_HDR : P_WAIT;
                 m_dest = a;
               end
      P_WAIT:  if (bus.fifo_empty[m_dest]) nxt = P_HDR;
      P_HDR:   nxt = P_PAY;
      P_PAY:   if (bus.fifo_full) nxt = P_FULL;
               else if (!bus.packet_valid) nxt = P_PAR;
      P_FULL:  if (!bus.fifo_full) nxt = P_AFTER;
      P_AFTER: nxt = bus.parity_done ? P_IDLE : (bus.low_packet_valid ? P_PAR : P_PAY);
      P_PAR:   nxt = P_CHK;
      default: nxt = bus.fifo_full ? P_FULL : P_IDLE;
    endcase
    m_phase = nxt;
    exp_q.push_back(expect_of(m_phase, m_dest));
  endtask

  function automatic logic [9:0] dut_out();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
            bus.write_enb_reg, bus.rst_int_reg, bus.busy, bus.dest_port};
  endfunction

  // Apply one cycle of inputs at the falling edge and record the prediction.
  task automatic cyc(logic pv, logic [1:0] din, logic full, logic [2:0] emp,
                     logic [2:0] srst, logic pd, logic lpv);
    bus.packet_valid = pv; bus.datain = din; bus.fifo_full = full;
    bus.fifo_empty = emp; bus.soft_reset = srst; bus.parity_done = pd;
    bus.low_packet_valid = lpv;
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m_phase = P_IDLE; m_dest = 2'd0;
    @(negedge clk);
    check("reset_state", dut_out(), expect_of(P_IDLE, 2'd0));
    resetn = 1'b1;
  endtask

  // Monitor: compare after each rising edge whenever a prediction is pending.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle_out", dut_out(), exp_q.pop_front());
    end
  end

  initial begin
    bus.packet_valid = 1'b0; bus.datain = 2'd0; bus.fifo_full = 1'b0;
    bus.fifo_empty = 3'b111; bus.soft_reset = 3'b000; bus.parity_done = 1'b0;
    bus.low_packet_valid = 1'b0;
    @(negedge clk);
    do_reset();

    // Minimum-latency packet to port 1, parity, then back to decode.
    cyc(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    // Three cycles of FIFO full, then release.
    repeat (3) cyc(1'b1, 2'd0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);

    // Header to a non-empty port 0, drains after four cycles.
    cyc(1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);

    // Invalid address held for five cycles.
    repeat (5) cyc(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);

    // Waiting on port 2: foreign soft reset ignored, own soft reset aborts.
    cyc(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 3'b011, 3'b001, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 3'b011, 3'b100, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);

    // Asynchronous reset in the middle of LOAD_DATA.
    cyc(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", {bus.detect_add, bus.ld_state, bus.dest_port}, {8'd0, 1'b1, 1'b0, 2'd0} & 10'h3ff);
    m_phase = P_IDLE; m_dest = 2'd0;
    @(negedge clk);
    resetn = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(3) != 0), 2'($urandom_range(3)), ($urandom_range(3) == 0),
          3'($urandom_range(7)), ($urandom_range(15) == 0) ? 3'($urandom_range(7)) : 3'b000,
          ($urandom_range(3) == 0), ($urandom_range(3) == 0));
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 10'(exp_q.size()), 10'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
